// File: rtl/z80_loader_if.sv
// Serial-receive, core and RAM bus signals seen by the z80 boot loader.
// The loader is the slave side; the environment (receiver, core, RAM) is the master.
interface z80_loader_if;
    logic [7:0]  rx_byte;
    logic        rx_ready;
    logic [15:0] cpu_address;
    logic        cpu_we;
    logic [7:0]  cpu_data_o;
    logic [7:0]  cpu_data_i;
    logic [15:0] mem_address;
    logic        mem_we;
    logic [7:0]  mem_data_o;
    logic [7:0]  mem_data_i;
    logic        cpu_run;
    logic        ok;
    logic        err;

    modport slave (
        input  rx_byte, rx_ready, cpu_address, cpu_we, cpu_data_o, mem_data_i,
        output cpu_data_i, mem_address, mem_we, mem_data_o, cpu_run, ok, err
    );

    modport master (
        output rx_byte, rx_ready, cpu_address, cpu_we, cpu_data_o, mem_data_i,
        input  cpu_data_i, mem_address, mem_we, mem_data_o, cpu_run, ok, err
    );
endinterface

// File: rtl/z80_loader.sv
// Boot loader and RAM bus owner in front of the z80 core: loads framed byte
// blocks into RAM while the core is stopped, then passes the bus through.
//
// state  | meaning
// IDLE   | waiting for the frame start byte
// CMD    | command byte expected
// AL/AH  | target address low/high byte
// LL/LH  | block length low/high byte
// DATA   | payload bytes, one RAM write each
// SUM    | checksum byte
module z80_loader #(
    parameter logic [7:0] SYNC  = 8'hA5,
    parameter logic [7:0] CMD_W = 8'h57,
    parameter logic [7:0] CMD_G = 8'h47,
    parameter logic [7:0] CMD_H = 8'h48
) (
    input  logic         clock,
    input  logic         reset_n,
    z80_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_AL, S_AH, S_LL, S_LH, S_DATA, S_SUM
    } state_t;

    state_t      state, state_nxt;
    logic        cpu_run, cpu_run_nxt;
    logic        ld_we, ld_we_nxt;
    logic [15:0] ld_addr, ld_addr_nxt;
    logic [7:0]  ld_data, ld_data_nxt;
    logic [15:0] ptr, ptr_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [7:0]  sum, sum_nxt;
    logic        ok, ok_nxt;
    logic        err, err_nxt;
    logic [7:0]  b;

    assign b = bus.rx_byte;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            cpu_run <= 1'b0;
            ld_we   <= 1'b0;
            ld_addr <= 16'h0000;
            ld_data <= 8'h00;
            ptr     <= 16'h0000;
            cnt     <= 16'h0000;
            sum     <= 8'h00;
            ok      <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            cpu_run <= cpu_run_nxt;
            ld_we   <= ld_we_nxt;
            ld_addr <= ld_addr_nxt;
            ld_data <= ld_data_nxt;
            ptr     <= ptr_nxt;
            cnt     <= cnt_nxt;
            sum     <= sum_nxt;
            ok      <= ok_nxt;
            err     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cpu_run_nxt = cpu_run;
        ld_we_nxt   = 1'b0;
        ld_addr_nxt = ld_addr;
        ld_data_nxt = ld_data;
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        sum_nxt     = sum;
        ok_nxt      = 1'b0;
        err_nxt     = err;
        if (bus.rx_ready) begin
            case (state)
                S_IDLE: begin
                    if (b == SYNC) begin
                        state_nxt = S_CMD;
                        err_nxt   = 1'b0;
                    end
                end
                S_CMD: begin
                    state_nxt = S_IDLE;
                    // A write block is only legal while the loader owns the bus.
                    if (b == CMD_W && !cpu_run) state_nxt = S_AL;
                    else if (b == CMD_G)        cpu_run_nxt = 1'b1;
                    else if (b == CMD_H)        cpu_run_nxt = 1'b0;
                    else                        err_nxt = 1'b1;
                end
                S_AL: begin
                    ptr_nxt[7:0] = b;
                    state_nxt    = S_AH;
                end
                S_AH: begin
                    ptr_nxt[15:8] = b;
                    state_nxt     = S_LL;
                end
                S_LL: begin
                    cnt_nxt[7:0] = b;
                    state_nxt    = S_LH;
                end
                S_LH: begin
                    cnt_nxt   = {b, cnt[7:0]};
                    sum_nxt   = 8'h00;
                    state_nxt = ({b, cnt[7:0]} == 16'h0000) ? S_SUM : S_DATA;
                end
                S_DATA: begin
                    ld_addr_nxt = ptr;
                    ld_data_nxt = b;
                    ld_we_nxt   = 1'b1;
                    ptr_nxt     = ptr + 16'd1;
                    sum_nxt     = sum + b;
                    cnt_nxt     = cnt - 16'd1;
                    if (cnt == 16'd1) state_nxt = S_SUM;
                end
                S_SUM: begin
                    if (b == sum) ok_nxt  = 1'b1;
                    else          err_nxt = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign bus.mem_address = cpu_run ? bus.cpu_address : ld_addr;
    assign bus.mem_we      = cpu_run ? bus.cpu_we      : ld_we;
    assign bus.mem_data_o  = cpu_run ? bus.cpu_data_o  : ld_data;
    assign bus.cpu_data_i  = bus.mem_data_i;
    assign bus.cpu_run     = cpu_run;
    assign bus.ok          = ok;
    assign bus.err         = err;
endmodule

// File: tb/tb_z80_loader.sv
// Bench for z80_loader: directed frames plus randomized blocks, checked
// against a byte-level RAM image and frame-level pulse counts.
module tb_z80_loader;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    z80_loader_if bus();
    z80_loader dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    logic [7:0] ram     [0:65535];
    logic [7:0] exp_ram [0:65535];
    logic [7:0] dq [$];

    always @(posedge clock) if (bus.mem_we) ram[bus.mem_address] <= bus.mem_data_o;
    assign bus.mem_data_i = ram[bus.mem_address];

    int checks = 0;
    int failures = 0;
    int we_cnt = 0;
    int ok_cnt = 0;

    always @(negedge clock) begin
        if (bus.mem_we) we_cnt++;
        if (bus.ok) ok_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge; returns at a negedge after 'gap' idle cycles.
    task automatic send(input logic [7:0] v, input int gap);
        bus.rx_byte  = v;
        bus.rx_ready = 1'b1;
        @(negedge clock);
        bus.rx_ready = 1'b0;
        repeat (gap) @(negedge clock);
    endtask

    // Sends a write frame carrying dq to addr; checksum offset by delta (0 = good).
    task automatic frame(input logic [15:0] addr, input logic [7:0] delta, input int maxgap);
        int we0, ok0, n;
        logic [7:0] s;
        logic [15:0] len, a;
        we0 = we_cnt;
        ok0 = ok_cnt;
        n   = dq.size();
        len = 16'(n);
        s   = 8'h00;
        send(8'hA5, $urandom_range(maxgap, 0));
        send(8'h57, $urandom_range(maxgap, 0));
        send(addr[7:0], $urandom_range(maxgap, 0));
        send(addr[15:8], $urandom_range(maxgap, 0));
        send(len[7:0], $urandom_range(maxgap, 0));
        send(len[15:8], $urandom_range(maxgap, 0));
        for (int i = 0; i < n; i++) begin
            a = addr + 16'(i);
            exp_ram[a] = dq[i];
            s = s + dq[i];
            send(dq[i], $urandom_range(maxgap, 0));
        end
        send(s + delta, 0);
        repeat (2) @(negedge clock);
        chk("we_pulses", 32'(we_cnt - we0), 32'(n));
        chk("ok_pulses", 32'(ok_cnt - ok0), (delta == 8'h00) ? 32'd1 : 32'd0);
        chk("err_after_frame", 32'(bus.err), (delta == 8'h00) ? 32'd0 : 32'd1);
        for (int i = 0; i < n; i++) begin
            a = addr + 16'(i);
            chk("ram_byte", 32'(ram[a]), 32'(exp_ram[a]));
        end
    endtask

    initial begin
        int we0;
        logic [7:0] junk;
        logic [15:0] ra;
        bus.rx_byte = 8'h00;
        bus.rx_ready = 1'b0;
        bus.cpu_address = 16'h0000;
        bus.cpu_we = 1'b0;
        bus.cpu_data_o = 8'h00;
        repeat (3) @(negedge clock);
        chk("rst_cpu_run", 32'(bus.cpu_run), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_ok", 32'(bus.ok), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        bus.cpu_we = 1'b1;
        #1 chk("rst_cpu_we_blocked", 32'(bus.mem_we), 32'd0);
        bus.cpu_we = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Frame A, back-to-back bytes
        dq = '{8'h11, 8'h22, 8'h33};
        frame(16'h1000, 8'h00, 0);
        // Same frame, bad checksum 67
        frame(16'h1000, 8'h01, 1);
        send(8'hA5, 0);
        @(negedge clock);
        chk("sync_clears_err", 32'(bus.err), 32'd0);
        send(8'h48, 1);
        chk("halt_idle_run", 32'(bus.cpu_run), 32'd0);

        // Address wrap
        dq = '{8'hAA, 8'hBB};
        frame(16'hFFFF, 8'h00, 1);
        // Zero length
        dq = {};
        frame(16'h2000, 8'h00, 0);

        // Release the core
        send(8'hA5, 0);
        send(8'h47, 1);
        chk("go_cpu_run", 32'(bus.cpu_run), 32'd1);
        bus.cpu_address = 16'h1000;
        bus.cpu_data_o = 8'($urandom);
        bus.cpu_we = 1'b1;
        #1;
        chk("run_mem_address", 32'(bus.mem_address), 32'h1000);
        chk("run_mem_we", 32'(bus.mem_we), 32'd1);
        chk("run_mem_data_o", 32'(bus.mem_data_o), 32'(bus.cpu_data_o));
        chk("run_cpu_data_i", 32'(bus.cpu_data_i), 32'(exp_ram[16'h1000]));
        bus.cpu_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ra = 16'($urandom);
            bus.cpu_address = ra;
            #1;
            chk("run_addr_follow", 32'(bus.mem_address), 32'(ra));
            chk("run_we_follow", 32'(bus.mem_we), 32'd0);
        end
        @(negedge clock);
        we0 = we_cnt;
        send(8'hA5, 0);
        send(8'h57, 1);
        chk("write_while_run_err", 32'(bus.err), 32'd1);
        chk("write_while_run_still_run", 32'(bus.cpu_run), 32'd1);
        chk("write_while_run_no_we", 32'(we_cnt - we0), 32'd0);
        send(8'hA5, 0);
        send(8'h48, 1);
        chk("halt_cpu_run", 32'(bus.cpu_run), 32'd0);
        chk("halt_err_cleared", 32'(bus.err), 32'd0);

        // Randomized blocks with junk between frames
        for (int r = 0; r < 6; r++) begin
            logic [15:0] fa;
            logic [7:0] d;
            int len;
            repeat ($urandom_range(2, 0)) begin
                junk = 8'($urandom);
                if (junk == 8'hA5) junk = 8'h00;
                send(junk, $urandom_range(1, 0));
            end
            fa = (r == 2) ? (16'hFFF8 + 16'($urandom_range(7, 0))) : 16'($urandom);
            len = $urandom_range(12, 0);
            dq = {};
            for (int i = 0; i < len; i++) dq.push_back(8'($urandom));
            d = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            frame(fa, d, 2);
        end

        // Reset in the middle of the payload
        send(8'hA5, 0);
        send(8'h57, 0);
        send(8'h00, 0);
        send(8'h30, 0);
        send(8'h05, 0);
        send(8'h00, 0);
        send(8'h5A, 0);
        send(8'h5B, 1);
        exp_ram[16'h3000] = 8'h5A;
        exp_ram[16'h3001] = 8'h5B;
        send(8'h5C, 0);
        reset_n = 1'b0;
        #1;
        chk("midrst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("midrst_mem_address", 32'(bus.mem_address), 32'h0000);
        chk("midrst_cpu_run", 32'(bus.cpu_run), 32'd0);
        chk("midrst_ok", 32'(bus.ok), 32'd0);
        chk("midrst_err", 32'(bus.err), 32'd0);
        chk("midrst_kept0", 32'(ram[16'h3000]), 32'h5A);
        chk("midrst_kept1", 32'(ram[16'h3001]), 32'h5B);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        dq = {};
        for (int i = 0; i < 4; i++) dq.push_back(8'($urandom));
        frame(16'h3000, 8'h00, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/z80_loader.md
# z80_loader

Boot loader and memory-bus owner placed directly in front of the `z80` core's memory port. It receives a framed byte stream from a serial receiver, writes the payload into the shared 64 KiB RAM, and then hands the RAM bus to the core. While loading, the core is held stopped via `cpu_run`. While running, the block is a transparent bus pass-through that watches only for a halt command.

## Interface
- `SYNC`, default 8'hA5: frame start byte.
- `CMD_W`, default 8'h57: write-block command.
- `CMD_G`, default 8'h47: go command (release the CPU).
- `CMD_H`, default 8'h48: halt command (reclaim the bus).
- `clock  in  1`: single clock, rising edge.
- `reset_n  in  1`: asynchronous, active-low reset.
- `rx_byte  in  8`: received serial byte, valid when `rx_ready`=1.
- `rx_ready  in  1`: one-cycle strobe per received byte. Back-to-back strobes are allowed.
- `cpu_address  in  16`: core address.
- `cpu_we  in  1`: core write enable.
- `cpu_data_o  in  8`: core write data.
- `cpu_data_i  out  8`: read data to the core. Always equal to `mem_data_i`.
- `mem_address  out  16`: RAM address.
- `mem_we  out  1`: RAM write enable.
- `mem_data_o  out  8`: RAM write data.
- `mem_data_i  in  8`: RAM read data (asynchronous read).
- `cpu_run  out  1`: 1 = core executes and owns the bus; 0 = core stopped.
- `ok  out  1`: one-cycle pulse when a write block's checksum matches.
- `err  out  1`: sticky error flag. Cleared when the next `SYNC` is accepted.

## Operation
- All state advances only on cycles with `rx_ready`=1, except the write pulse and the reset.
- **Bus mux**
  - When `cpu_run`=1, `mem_address`/`mem_we`/`mem_data_o` combinationally equal `cpu_address`/`cpu_we`/`cpu_data_o`.
  - When `cpu_run`=0, they come from the loader registers `ld_addr`/`ld_we`/`ld_data`.
- **FSM states:** IDLE, CMD, AL, AH, LL, LH, DATA, SUM.
  - IDLE: byte == `SYNC` → CMD, `err`<=0. Any other byte is ignored.
  - CMD, `CMD_W` while not running → AL.
  - CMD, `CMD_G` → IDLE, `cpu_run`<=1.
  - CMD, `CMD_H` → IDLE, `cpu_run`<=0.
  - CMD, any other byte, or `CMD_W` while running → IDLE, `err`<=1.
  - While `cpu_run`=1, only the `SYNC`,`CMD_H` / `SYNC`,`CMD_G` pair has effect. A `CMD_W` is rejected as above.
  - AL/AH: load `ptr[7:0]`/`ptr[15:8]`.
  - LL/LH: load `cnt[7:0]`/`cnt[15:8]`. Leaving LH: `cnt`==0 → SUM, otherwise → DATA. `sum`<=0.
  - DATA: each byte registers `ld_addr`<=`ptr`, `ld_data`<=byte, `ld_we`<=1 for exactly one cycle. Then `ptr`<=`ptr`+1 (wraps at 16'hFFFF → 0000), `sum`<=`sum`+byte (mod 256), `cnt`<=`cnt`-1. When `cnt` reaches 0 → SUM.
  - SUM: byte == `sum` → `ok` pulse. Otherwise `err`<=1. Either way → IDLE.
- Bytes already written stay in RAM on a checksum mismatch. No rollback.
- `ld_we` deasserts the cycle after any write, regardless of the next `rx_ready`.
- **Reset** (asynchronous, any time, including mid-frame):
  - State IDLE, `cpu_run`=0, `ld_we`=0, `ld_addr`=0, `ld_data`=0.
  - `ptr`=`cnt`=0, `sum`=0, `ok`=0, `err`=0.
  - RAM contents are untouched.

## Timing
- Write latency: `rx_ready` in DATA at edge k → `mem_we`=1 during cycle k..k+1, with `mem_address` = target address.
- `cpu_run` rises on the edge that samples `CMD_G`. The mux switches in the same cycle as the register change.
- On the edge that samples `CMD_H`, `cpu_run` falls. The core may lose an in-flight instruction; this is accepted.
- `ok` is high for exactly one cycle after the SUM byte edge.
- `err` is set on the offending byte's edge and holds until the next accepted `SYNC`.
- After release, the core starts from its own power-up PC (0000). The loader does not modify the PC.

## Test plan
- After reset: `cpu_run`=0, `mem_we`=0, `ok`=0, `err`=0. Drive `cpu_we`=1 → `mem_we` stays 0.
- Stream A5 57 00 10 03 00 11 22 33 66 → RAM[1000..1002]=11,22,33. Three one-cycle `mem_we` pulses. `ok` pulses once, `err`=0.
- Same frame with checksum byte 67 → RAM is still written, `err`=1, no `ok`. A following A5 clears `err`.
- Wrap: A5 57 FF FF 02 00 AA BB 65 → RAM[FFFF]=AA, RAM[0000]=BB, `ok`.
- Zero length: A5 57 00 20 00 00 00 → no writes, `ok`. Then A5 47 → `cpu_run`=1 and `mem_address` follows `cpu_address`. A5 57 while running → `err`=1, and `mem_we` tracks `cpu_we` only.
- Assert `reset_n`=0 in the middle of the DATA phase → all outputs return to reset values immediately. A fresh frame then loads correctly.
